// File: rtl/booth_multiplier.sv
// Sequential signed multiplier using Booth recoding: radix-2 by default, or radix-4
// (modified Booth) when BOOTH_RADIX4_EN is defined. Same start/valid handshake as the Booth divider.
module booth_multiplier #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [N-1:0]   X,
  input  logic signed [N-1:0]   Y,
  output logic signed [2*N-1:0] Z,
  output logic                  valid
);

`ifdef BOOTH_RADIX4_EN
  localparam int SH    = 2;
  localparam int AW    = N + 2;
  localparam int STEPS = N / 2;
`else
  localparam int SH    = 1;
  localparam int AW    = N + 1;
  localparam int STEPS = N;
`endif
  localparam int CW   = $clog2(N + 1);
  localparam int CATW = AW + N + 1;

  generate
    if (N < 2) begin : g_bad_n
      $error("booth_multiplier: N must be >= 2");
    end
`ifdef BOOTH_RADIX4_EN
    if (N % 2 != 0) begin : g_odd_n
      $error("booth_multiplier: radix-4 build needs an even N");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  m_q, m_d;
  logic signed [AW-1:0]  a_q, a_d;
  logic [N-1:0]          q_q, q_d;
  logic                  q1_q, q1_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [2*N-1:0] z_q, z_d;
  logic                  valid_q, valid_d;

  logic signed [AW-1:0]   addend;
  logic signed [AW-1:0]   sum;
  logic signed [CATW-1:0] cat;
  logic signed [CATW-1:0] shifted;

  // One Booth step: recode, add, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    addend = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1:0], q1_q})
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q <<< 1;
      3'b100:         addend = -(m_q <<< 1);
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
`else
    case ({q_q[0], q1_q})
      2'b01:   addend = m_q;
      2'b10:   addend = -m_q;
      default: addend = '0;
    endcase
`endif
    sum     = a_q + addend;
    cat     = {sum, q_q, q1_q};
    shifted = cat >>> SH;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = {{(AW-N){X[N-1]}}, X};
          a_d     = '0;
          q_d     = Y;
          q1_d    = 1'b0;
          cnt_d   = CW'(STEPS);
          valid_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = shifted[CATW-1 -: AW];
        q_d   = shifted[N:1];
        q1_d  = shifted[0];
        cnt_d = cnt_q - 1'b1;
        // Z is only written on the final step so it holds through CALC.
        if (cnt_q == CW'(1)) begin
          z_d     = shifted[2*N:1];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end

  assign Z     = z_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier (N=4); latency follows BOOTH_RADIX4_EN.
module tb_booth_multiplier;
  localparam int N = 4;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic signed [N-1:0]   X = '0;
  logic signed [N-1:0]   Y = '0;
  logic signed [2*N-1:0] Z;
  logic                  valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [N-1:0]   x;
    logic signed [N-1:0]   y;
    logic signed [2*N-1:0] z;
  } vec_t;

  vec_t tbl[6];

  booth_multiplier #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .Z(Z), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic signed [N-1:0] x, input logic signed [N-1:0] y,
                       input logic signed [2*N-1:0] exp, input string nm);
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " valid after accept"}, longint'(valid), 0);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      if (i < LAT) chk({nm, " valid early"}, longint'(valid), 0);
    end
    chk({nm, " valid"}, longint'(valid), 1);
    chk({nm, " Z"}, longint'(Z), longint'(exp));
  endtask

  initial begin
    int npulse;
    tbl[0] = '{4'(7),  4'(6),  8'(42)};
    tbl[1] = '{4'(-8), 4'(-8), 8'(64)};
    tbl[2] = '{4'(-8), 4'(7),  8'(-56)};
    tbl[3] = '{4'(7),  4'(-1), 8'(-7)};
    tbl[4] = '{4'(0),  4'(-5), 8'(0)};
    tbl[5] = '{4'(-1), 4'(-1), 8'(1)};

    #12;
    chk("reset valid", longint'(valid), 0);
    chk("reset Z", longint'(Z), 0);
    @(negedge clk);
    rst = 1'b1;

    do_op(4'(7), 4'(2), 8'(14), "7*2");
    repeat (3) @(posedge clk);
    #1;
    chk("hold valid", longint'(valid), 1);
    chk("hold Z", longint'(Z), 14);

    for (int i = 0; i < 6; i++)
      do_op(tbl[i].x, tbl[i].y, tbl[i].z, $sformatf("tbl%0d", i));

    // start re-pulsed during CALC must be ignored
    @(negedge clk);
    X = 4'(3); Y = 4'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    X = 4'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; X = '0;
    for (int i = 2; i <= LAT; i++) begin
      @(posedge clk); #1;
    end
    chk("calc-ignore valid", longint'(valid), 1);
    chk("calc-ignore Z", longint'(Z), 9);
    @(posedge clk); #1;
    chk("calc-ignore hold valid", longint'(valid), 1);
    chk("calc-ignore hold Z", longint'(Z), 9);

    // start held high: one valid cycle per result
    @(negedge clk);
    X = 4'(2); Y = 4'(3); start = 1'b1;
    @(posedge clk);
    npulse = 0;
    for (int i = 1; i <= 2 * LAT + 1; i++) begin
      @(posedge clk); #1;
      if (valid) npulse++;
    end
    start = 1'b0;
    chk("b2b valid pulses", longint'(npulse), 2);
    chk("b2b Z", longint'(Z), 6);
    chk("b2b valid end", longint'(valid), 1);

    // asynchronous reset mid-CALC
    @(negedge clk);
    X = 4'(3); Y = 4'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT / 2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midreset valid", longint'(valid), 0);
    chk("midreset Z", longint'(Z), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_op(4'(-3), 4'(5), 8'(-15), "-3*5");

    for (int xi = -8; xi < 8; xi++)
      for (int yi = -8; yi < 8; yi++)
        do_op(4'(xi), 4'(yi), 8'(xi * yi), $sformatf("exh %0d*%0d", xi, yi));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed multiplier using radix-2 Booth recoding. Companion to the team's Booth divider in the lab arithmetic set, performing the inverse operation.
- Same start/valid handshake style and operand/result layout as the divider, so both drop into the same bench harness.
- Computes Z = X * Y over N iterations for two's-complement N-bit operands, giving a 2N-bit product.

Parameters:
- N, 4, operand width in bits; must be >= 2. Product width is 2N.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE
- X  input  N  signed multiplicand; captured on the accepting edge
- Y  input  N  signed multiplier; captured on the accepting edge
- Z  output  2N  signed product; held stable while valid=1
- valid  output  1  result-ready level

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; Z=0; valid=0; all internal registers cleared.
- Internal registers:
  - M: N+1 bits, sign-extended X.
  - A: N+1 bits, accumulator.
  - Q: N bits, holds Y.
  - q_1: 1 bit.
  - cnt: ceil(log2(N+1)) bits.
- The N+1-bit width of A and M allows -M to be formed when X = -2^(N-1) without overflow.
- States: IDLE, CALC, DONE.
- IDLE, start=1: load M=sext(X), Q=Y, A=0, q_1=0, cnt=N. Go to CALC.
- CALC, each edge:
  - Examine {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add.
  - Then arithmetic-shift {A,Q,q_1} right by 1, replicating A's MSB.
  - Decrement cnt.
- CALC, edge where cnt==1 (last iteration): write Z = low 2N bits of the post-shift {A,Q}; set valid=1; go to DONE.
- Latency: start accepted at edge E0 -> valid=1 and Z correct immediately after edge E0+N. For N=4, 4 cycles after the accept edge.
- DONE:
  - valid stays 1 and Z holds until the next accepted start.
  - start=1: reload exactly as in IDLE, clear valid on the same edge, go to CALC. Z keeps the old value until overwritten.
- start during CALC is ignored; X/Y changes during CALC have no effect.
- start held high continuously: back-to-back operations; valid is high for exactly one cycle per result.
- rst asserted mid-CALC: the operation is aborted immediately and the reset values above apply.
- Valid for every operand pair, including -2^(N-1) * -2^(N-1) = 2^(2N-2); the result always fits in 2N bits.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined:
  - Radix-4 (modified Booth) recoding on {Q[1:0],q_1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Shift right by 2 per step; A and M widened to N+2 bits; cnt starts at N/2.
  - Latency N/2 cycles (2 cycles for N=4).
  - N must be even; an odd N is a compile-time error.
- Undefined: radix-2 behaviour as above. Ports and handshake are identical in both builds.

Test Plan:
- Reset, then X=7, Y=2, start pulsed one cycle -> valid rises 4 edges after accept, Z=14. valid and Z hold while start=0.
- From DONE: X=7, Y=6, start pulse -> valid drops next edge; Z=42 after 4 edges.
- Sign corners: (-8)*(-8) -> 64; (-8)*7 -> -56; 7*(-1) -> -7; 0*(-5) -> 0; (-1)*(-1) -> 1.
- X=3, Y=3 started, then start re-pulsed with X=5 during CALC -> ignored; Z=9 at the normal time.
- rst driven low 2 cycles into CALC, asynchronously between edges -> valid=0 and Z=0 at once. After release, X=-3, Y=5 -> Z=-15.
- BOOTH_RADIX4_EN defined, N=4: exhaustive 256 operand pairs -> Z = X*Y, each with valid 2 edges after accept. Repeat exhaustive 256 pairs with the macro undefined, expecting 4-edge latency.
